// File: rtl/vec_mac_accumulator_if.sv
// Handshake bundle for the vector dot-product accumulate stage.
// master drives beats/commands and consumes results; slave is the accumulator.
interface vec_mac_accumulator_if #(
    parameter int LANES = 4,
    parameter int ACC_W = 16,
    parameter int LEN_W = 8
) ();
    logic                   start;
    logic [LEN_W-1:0]       vlen;
    logic [LANES*8-1:0]     prod;
    logic                   in_valid;
    logic                   in_ready;
    logic [ACC_W-1:0]       acc_out;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;
    logic                   sat_flag;

    modport master (
        output start, vlen, prod, in_valid, out_ready,
        input  in_ready, acc_out, out_valid, busy, sat_flag
    );

    modport slave (
        input  start, vlen, prod, in_valid, out_ready,
        output in_ready, acc_out, out_valid, busy, sat_flag
    );
endinterface

// File: rtl/vec_mac_accumulator.sv
// Accumulate stage of the vector dot-product: reduces LANES signed 8-bit products per beat
// over vlen beats. Define SAT_ACC_EN to clamp each addition instead of wrapping.
module vec_mac_accumulator #(
    parameter int LANES = 4,
    parameter int ACC_W = 16,
    parameter int LEN_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    vec_mac_accumulator_if.slave  bus
);
    localparam int LS_W = 8 + $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic signed [ACC_W-1:0] acc_reg, acc_next;
    logic [LEN_W-1:0]        count_reg, count_next;

    logic signed [LS_W-1:0]  lane_ext [LANES];
    logic signed [LS_W-1:0]  lane_sum;
    logic signed [ACC_W-1:0] sum_res;
    logic                    beat_acc;
    logic                    start_acc;

    assign beat_acc  = (state_reg == ACCUM) && bus.in_valid;
    assign start_acc = (state_reg == IDLE) && bus.start;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_ext[gi] = LS_W'($signed(bus.prod[8*gi +: 8]));
        end
    endgenerate

    // LS_W is wide enough that the lane reduction itself can never overflow.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + lane_ext[i];
        end
    end

`ifdef SAT_ACC_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] sum_wide;
    logic                  sum_ovf;
    logic                  sat_reg, sat_next;

    always_comb begin
        sum_wide = (ACC_W+1)'(acc_reg) + (ACC_W+1)'(lane_sum);
        // The two top bits disagree exactly when the sum left the ACC_W range.
        sum_ovf  = sum_wide[ACC_W] != sum_wide[ACC_W-1];
        if (sum_ovf) begin
            sum_res = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            sum_res = sum_wide[ACC_W-1:0];
        end
    end

    always_comb begin
        sat_next = sat_reg;
        if (start_acc) begin
            sat_next = 1'b0;
        end else if (beat_acc && sum_ovf) begin
            sat_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_reg <= 1'b0;
        end else begin
            sat_reg <= sat_next;
        end
    end

    assign bus.sat_flag = sat_reg;
`else
    assign sum_res      = acc_reg + ACC_W'(lane_sum);
    assign bus.sat_flag = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                if (start_acc) begin
                    acc_next = '0;
                    if (bus.vlen != '0) begin
                        count_next = bus.vlen;
                        state_next = ACCUM;
                    end else begin
                        state_next = HOLD;
                    end
                end
            end
            ACCUM: begin
                if (beat_acc) begin
                    acc_next   = sum_res;
                    count_next = count_reg - LEN_W'(1);
                    if (count_reg == LEN_W'(1)) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            count_reg <= count_next;
        end
    end

    assign bus.in_ready  = (state_reg == ACCUM);
    assign bus.out_valid = (state_reg == HOLD);
    assign bus.busy      = (state_reg != IDLE);
    assign bus.acc_out   = acc_reg;
endmodule

// File: tb/tb_vec_mac_accumulator.sv
// Bench for vec_mac_accumulator: directed plan cases plus random operations, all outputs
// compared every cycle against an integer-arithmetic reference model.
module tb_vec_mac_accumulator;
    localparam int LANES   = 4;
    localparam int ACC_W   = 16;
    localparam int LEN_W   = 8;
    localparam int ACC_MAX = 2**(ACC_W-1) - 1;
    localparam int ACC_MIN = -(2**(ACC_W-1));

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vec_mac_accumulator_if #(.LANES(LANES), .ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

    vec_mac_accumulator #(.LANES(LANES), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: phase 0 idle, 1 collecting beats, 2 result offered.
    int m_phase = 0;
    int m_acc   = 0;
    int m_left  = 0;
    bit m_sat   = 1'b0;

    function automatic int lane_total(input logic [LANES*8-1:0] p);
        int s = 0;
        for (int i = 0; i < LANES; i++) s += int'($signed(p[8*i +: 8]));
        return s;
    endfunction

    function automatic int resolve(input int s);
`ifdef SAT_ACC_EN
        if (s > ACC_MAX) return ACC_MAX;
        if (s < ACC_MIN) return ACC_MIN;
        return s;
`else
        logic signed [ACC_W-1:0] t;
        t = s[ACC_W-1:0];
        return int'(t);
`endif
    endfunction

    function automatic bit overflows(input int s);
`ifdef SAT_ACC_EN
        return (s > ACC_MAX) || (s < ACC_MIN);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [ACC_W-1:0] to_acc(input int v);
        return v[ACC_W-1:0];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_acc   <= 0;
            m_left  <= 0;
            m_sat   <= 1'b0;
        end else begin
            case (m_phase)
                0: if (bus.start) begin
                    m_acc <= 0;
                    m_sat <= 1'b0;
                    if (bus.vlen != 0) begin
                        m_phase <= 1;
                        m_left  <= int'(bus.vlen);
                    end else begin
                        m_phase <= 2;
                    end
                end
                1: if (bus.in_valid) begin
                    m_acc  <= resolve(m_acc + lane_total(bus.prod));
                    if (overflows(m_acc + lane_total(bus.prod))) m_sat <= 1'b1;
                    m_left <= m_left - 1;
                    if (m_left == 1) m_phase <= 2;
                end
                2: if (bus.out_ready) m_phase <= 0;
                default: m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        check("in_ready",  32'(bus.in_ready),  32'(m_phase == 1));
        check("out_valid", 32'(bus.out_valid), 32'(m_phase == 2));
        check("busy",      32'(bus.busy),      32'(m_phase != 0));
        check("sat_flag",  32'(bus.sat_flag),  32'(m_sat));
        check("acc_out",   32'(bus.acc_out),   32'(to_acc(m_acc)));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LANES*8-1:0] rand_prod(input int bias);
        logic [LANES*8-1:0] p;
        for (int i = 0; i < LANES; i++) begin
            case (bias)
                1:       p[8*i +: 8] = 8'($urandom_range(96, 127));
                2:       p[8*i +: 8] = 8'($urandom_range(128, 160));
                default: p[8*i +: 8] = 8'($urandom_range(0, 255));
            endcase
        end
        return p;
    endfunction

    task automatic do_start(input int v);
        bus.start = 1'b1;
        bus.vlen  = LEN_W'(v);
        tick();
        bus.start = 1'b0;
        bus.vlen  = LEN_W'($urandom);
    endtask

    task automatic send_beat(input logic [LANES*8-1:0] p, input int gap);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.prod     = p;
        while (!bus.in_ready && waited < 50) begin
            tick();
            waited++;
        end
        check("beat_ready_seen", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.prod     = rand_prod(0);
        repeat (gap) tick();
    endtask

    task automatic get_result(input int hold, output logic [ACC_W-1:0] res);
        int waited = 0;
        while (!bus.out_valid && waited < 50) begin
            tick();
            waited++;
        end
        check("out_valid_seen", 32'(bus.out_valid), 32'd1);
        res = bus.acc_out;
        repeat (hold) begin
            tick();
            check("acc_out_stable", 32'(bus.acc_out), 32'(res));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [ACC_W-1:0] res;
        bus.start     = 1'b0;
        bus.vlen      = '0;
        bus.prod      = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_sat_flag",  32'(bus.sat_flag),  32'd0);
        check("rst_acc_out",   32'(bus.acc_out),   32'd0);
        rst = 1'b0;
        tick();

        // Single beat, lanes {3,-2,5,1}
        do_start(1);
        check("single_in_ready", 32'(bus.in_ready), 32'd1);
        send_beat({8'h01, 8'h05, 8'hFE, 8'h03}, 0);
        check("single_latency", 32'(bus.out_valid), 32'd1);
        get_result(0, res);
        check("single_result", 32'(res), 32'h0007);
        check("single_model",  32'(to_acc(m_acc)), 32'h0007);
        check("single_sat",    32'(bus.sat_flag), 32'd0);

        // Gapped input, every lane 0x10
        do_start(3);
        repeat (3) send_beat({LANES{8'h10}}, 2);
        get_result(0, res);
        check("gapped_result", 32'(res), 32'h00C0);

        // Output backpressure with start pulsed while holding
        do_start(1);
        send_beat({8'h02, 8'h02, 8'h02, 8'h02}, 0);
        bus.start = 1'b1;
        bus.vlen  = LEN_W'(5);
        repeat (5) begin
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready",  32'(bus.in_ready),  32'd0);
            check("bp_busy",      32'(bus.busy),      32'd1);
            check("bp_acc_out",   32'(bus.acc_out),   32'h0008);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        check("bp_idle_after", 32'(bus.busy), 32'd0);
        tick();
        check("bp_start_ignored", 32'(bus.busy), 32'd0);

        // Overflow: 200 beats of all-0x7F lanes
        do_start(200);
        repeat (200) send_beat({LANES{8'h7F}}, int'($urandom_range(0, 1)));
        get_result(1, res);
`ifdef SAT_ACC_EN
        check("ovf_result", 32'(res), 32'h7FFF);
        check("ovf_sat",    32'(bus.sat_flag), 32'd1);
`else
        check("ovf_result", 32'(res), 32'h8CE0);
        check("ovf_sat",    32'(bus.sat_flag), 32'd0);
`endif

        // Negative products, then zero length
        do_start(2);
        check("neg_sat_cleared", 32'(bus.sat_flag), 32'd0);
        repeat (2) send_beat({LANES{8'h80}}, 0);
        get_result(0, res);
        check("neg_result", 32'(res), 32'hFC00);
        check("neg_model",  32'(to_acc(m_acc)), 32'hFC00);
        do_start(0);
        check("zero_out_valid", 32'(bus.out_valid), 32'd1);
        get_result(0, res);
        check("zero_result", 32'(res), 32'h0000);

        // Reset mid-accumulation
        do_start(5);
        repeat (2) send_beat({LANES{8'h11}}, 0);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        check("midrst_busy",     32'(bus.busy),     32'd0);
        check("midrst_acc_out",  32'(bus.acc_out),  32'd0);
        tick();
        rst = 1'b0;
        tick();
        do_start(1);
        send_beat({LANES{8'h01}}, 0);
        get_result(0, res);
        check("after_rst_result", 32'(res), 32'h0004);

        // Random operations
        for (int op = 0; op < 40; op++) begin
            int v;
            int bias;
            bias = int'($urandom_range(0, 2));
            v = ($urandom_range(0, 7) == 0) ? int'($urandom_range(100, 255))
                                            : int'($urandom_range(0, 12));
            do_start(v);
            for (int b = 0; b < v; b++) send_beat(rand_prod(bias), int'($urandom_range(0, 2)));
            get_result(int'($urandom_range(0, 3)), res);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
